// File: rtl/sata_link_ctrl.sv
// Per-port SATA link bring-up sequencer: PHY reset, OOB start, CommInit/linkup
// supervision with timeouts, bounded retry with backoff, and link-loss recovery.
module sata_link_ctrl #(
    parameter int unsigned C_RST_CYCLES   = 16,
    parameter logic [19:0] C_INIT_TIMEOUT = 20'd400000,
    parameter logic [19:0] C_LINK_TIMEOUT = 20'd800000,
    parameter logic [19:0] C_BACKOFF      = 20'd100000,
    parameter int unsigned C_MAX_RETRY    = 3,
    parameter int unsigned C_LOSS_FILTER  = 4
) (
    input  logic       phyclk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       restart,
    input  logic       plllock,
    input  logic       CommInit,
    input  logic       linkup,
    output logic       phyreset,
    output logic       StartComm,
    output logic       link_ready,
    output logic       link_fail,
    output logic [3:0] retry_cnt,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_PLL  = 4'd1,
        S_PHY_RST   = 4'd2,
        S_START     = 4'd3,
        S_WAIT_INIT = 4'd4,
        S_WAIT_LINK = 4'd5,
        S_LINKED    = 4'd6,
        S_BACKOFF   = 4'd7,
        S_FAIL      = 4'd8
    } state_t;

    localparam logic [19:0] RST_LOAD  = 20'(C_RST_CYCLES - 1);
    localparam logic [19:0] INIT_LOAD = C_INIT_TIMEOUT - 20'd1;
    localparam logic [19:0] LINK_LOAD = C_LINK_TIMEOUT - 20'd1;
    localparam logic [19:0] BOFF_LOAD = C_BACKOFF - 20'd1;
    localparam logic [7:0]  LOSS_LAST = 8'(C_LOSS_FILTER - 1);
    localparam logic [3:0]  MAX_RETRY = 4'(C_MAX_RETRY);

    state_t      state_q, state_d;
    logic [19:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  loss_q, loss_d;
    logic        phyreset_q, phyreset_d;
    logic        start_q, start_d;
    logic        ready_q, ready_d;
    logic        fail_q, fail_d;
    logic        attempt_failed;
    logic [3:0]  retry_inc;
    logic        timeout;

    // Next-state, timer, retry and loss-filter logic; outputs decoded from the next state
    // so every output is a register that matches the state it belongs to.
    always_comb begin
        state_d        = state_q;
        timer_d        = (timer_q != '0) ? timer_q - 20'd1 : '0;
        retry_d        = retry_q;
        loss_d         = '0;
        attempt_failed = 1'b0;
        timeout        = (timer_q == '0);
        retry_inc      = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

        if (!enable) begin
            state_d = S_IDLE;
        end else if (restart) begin
            retry_d = '0;
            state_d = S_WAIT_PLL;
        end else if (!plllock && !(state_q inside {S_IDLE, S_WAIT_PLL, S_FAIL})) begin
            state_d = S_WAIT_PLL;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_WAIT_PLL;
                S_WAIT_PLL: begin
                    if (plllock) begin
                        state_d = S_PHY_RST;
                        timer_d = RST_LOAD;
                    end
                end
                S_PHY_RST: begin
                    if (timeout) state_d = S_START;
                end
                S_START: begin
                    state_d = S_WAIT_INIT;
                    timer_d = INIT_LOAD;
                end
                S_WAIT_INIT: begin
                    if (CommInit) begin
                        state_d = S_WAIT_LINK;
                        timer_d = LINK_LOAD;
                    end else if (timeout) begin
                        attempt_failed = 1'b1;
                    end
                end
                S_WAIT_LINK: begin
                    if (linkup) begin
                        state_d = S_LINKED;
                        retry_d = '0;
                    end else if (timeout) begin
                        attempt_failed = 1'b1;
                    end
                end
                S_LINKED: begin
                    if (!linkup) begin
                        if (loss_q == LOSS_LAST) begin
                            state_d = S_PHY_RST;
                            timer_d = RST_LOAD;
                        end else begin
                            loss_d = loss_q + 8'd1;
                        end
                    end
                end
                S_BACKOFF: begin
                    if (timeout) begin
                        state_d = S_PHY_RST;
                        timer_d = RST_LOAD;
                    end
                end
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_IDLE;
            endcase

            if (attempt_failed) begin
                retry_d = retry_inc;
                if (retry_inc >= MAX_RETRY) begin
                    state_d = S_FAIL;
                end else begin
                    state_d = S_BACKOFF;
                    timer_d = BOFF_LOAD;
                end
            end
        end

        phyreset_d = !(state_d inside {S_START, S_WAIT_INIT, S_WAIT_LINK, S_LINKED});
        start_d    = (state_d == S_START);
        ready_d    = (state_d == S_LINKED);
        fail_d     = (state_d == S_FAIL);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge phyclk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            phyreset_q <= 1'b1;
            start_q    <= 1'b0;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            phyreset_q <= phyreset_d;
            start_q    <= start_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    assign phyreset   = phyreset_q;
    assign StartComm  = start_q;
    assign link_ready = ready_q;
    assign link_fail  = fail_q;
    assign retry_cnt  = retry_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_sata_link_ctrl.sv
// Self-checking bench for sata_link_ctrl: directed bring-up scenarios plus randomized
// stimulus, compared every cycle against a behavioural model of the sequencer.
module tb_sata_link_ctrl;

    localparam int RST  = 4;
    localparam int INIT = 20;
    localparam int LINK = 20;
    localparam int BOFF = 10;
    localparam int MAXR = 3;
    localparam int LOSS = 4;

    logic       phyclk = 1'b0;
    logic       rst_n = 1'b0, enable = 1'b0, restart = 1'b0, plllock = 1'b0;
    logic       CommInit = 1'b0, linkup = 1'b0;
    logic       phyreset, StartComm, link_ready, link_fail;
    logic [3:0] retry_cnt, state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    sata_link_ctrl #(
        .C_RST_CYCLES  (RST),
        .C_INIT_TIMEOUT(20'd20),
        .C_LINK_TIMEOUT(20'd20),
        .C_BACKOFF     (20'd10),
        .C_MAX_RETRY   (MAXR),
        .C_LOSS_FILTER (LOSS)
    ) dut (
        .phyclk    (phyclk),
        .rst_n     (rst_n),
        .enable    (enable),
        .restart   (restart),
        .plllock   (plllock),
        .CommInit  (CommInit),
        .linkup    (linkup),
        .phyreset  (phyreset),
        .StartComm (StartComm),
        .link_ready(link_ready),
        .link_fail (link_fail),
        .retry_cnt (retry_cnt),
        .state_dbg (state_dbg)
    );

    always #5 phyclk = ~phyclk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_st uses the documented state numbers; m_el counts cycles already spent in the
    // current state, so a state with an N-cycle budget is left after its N-th cycle.
    int m_st = 0, m_el = 0, m_retry = 0, m_low = 0;

    always @(posedge phyclk) begin
        int nst;
        bit failed;
        nst = m_st;
        failed = 0;
        if (!rst_n) begin
            m_st = 0; m_el = 0; m_retry = 0; m_low = 0;
        end else begin
            if (!enable) nst = 0;
            else if (restart) begin m_retry = 0; nst = 1; end
            else if (!plllock && m_st != 0 && m_st != 1 && m_st != 8) nst = 1;
            else begin
                case (m_st)
                    0: nst = 1;
                    1: if (plllock) nst = 2;
                    2: if (m_el == RST - 1) nst = 3;
                    3: nst = 4;
                    4: if (CommInit) nst = 5; else if (m_el == INIT - 1) failed = 1;
                    5: if (linkup) begin nst = 6; m_retry = 0; end
                       else if (m_el == LINK - 1) failed = 1;
                    6: if (linkup) m_low = 0;
                       else begin m_low++; if (m_low == LOSS) nst = 2; end
                    7: if (m_el == BOFF - 1) nst = 2;
                    default: nst = m_st;
                endcase
                if (failed) begin
                    m_retry = (m_retry == 15) ? 15 : m_retry + 1;
                    nst = (m_retry >= MAXR) ? 8 : 7;
                end
            end
            if (nst != 6) m_low = 0;
            m_el = (nst == m_st) ? m_el + 1 : 0;
            m_st = nst;
        end
    end

    function automatic int exp_vec();
        int pr;
        pr = (m_st == 3 || m_st == 4 || m_st == 5 || m_st == 6) ? 0 : 1;
        return (pr << 11) | (int'(m_st == 3) << 10) | (int'(m_st == 6) << 9) |
               (int'(m_st == 8) << 8) | (m_retry << 4) | m_st;
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge phyclk) begin
        check("cycle_vs_model",
              int'({phyreset, StartComm, link_ready, link_fail, retry_cnt, state_dbg}),
              exp_vec());
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge phyclk);
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n;
        n = 0;
        while (int'(state_dbg) != s && n < budget) begin tick(); n++; end
        if (int'(state_dbg) != s) check({name, "_timeout"}, int'(state_dbg), s);
    endtask

    task automatic count_in_state(input int s, output int n);
        n = 0;
        while (int'(state_dbg) == s && n < 200) begin tick(); n++; end
    endtask

    initial begin
        int n;
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int prof;
        // ---- reset state ----
        repeat (3) tick();
        check("rst_phyreset", phyreset, 1);
        check("rst_startcomm", StartComm, 0);
        check("rst_ready", link_ready, 0);
        check("rst_fail", link_fail, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_state", state_dbg, 0);

        // ---- 1. nominal bring-up ----
        rst_n = 1; enable = 1; plllock = 1;
        wait_state(2, 10, "t1_phyrst");
        count_in_state(2, n);
        check("t1_phyrst_len", n, 4);
        check("t1_startcomm", StartComm, 1);
        check("t1_phyreset_low", phyreset, 0);
        tick();
        check("t1_startcomm_once", StartComm, 0);
        repeat (4) tick();
        CommInit = 1; tick(); CommInit = 0;
        check("t1_wait_link", state_dbg, 5);
        repeat (2) tick();
        linkup = 1; tick();
        check("t1_ready", link_ready, 1);
        check("t1_retry", retry_cnt, 0);

        // ---- 4. link-loss filter ----
        linkup = 0; repeat (3) tick();
        linkup = 1; tick();
        check("t4_glitch_stays", state_dbg, 6);
        linkup = 0; repeat (4) tick();
        check("t4_loss_state", state_dbg, 2);
        check("t4_loss_ready", link_ready, 0);
        check("t4_loss_retry", retry_cnt, 0);

        // ---- 5. plllock drop in WAIT_LINK ----
        wait_state(4, 20, "t5_init");
        CommInit = 1; tick(); CommInit = 0;
        plllock = 0; tick();
        check("t5_pll_drop", state_dbg, 1);
        repeat (2) tick();
        check("t5_pll_hold", state_dbg, 1);
        plllock = 1;
        wait_state(4, 20, "t5_resume");
        CommInit = 1; tick(); CommInit = 0;
        linkup = 1; tick();
        check("t5_relinked", link_ready, 1);

        // ---- 2. no device: three attempts then FAIL ----
        linkup = 0; restart = 1; tick(); restart = 0;
        for (int a = 1; a <= 3; a++) begin
            wait_state(4, 30, "t2_init");
            count_in_state(4, n);
            check("t2_init_len", n, INIT);
            check("t2_retry", retry_cnt, a);
            if (a < 3) begin
                check("t2_backoff", state_dbg, 7);
                count_in_state(7, n);
                check("t2_backoff_len", n, BOFF);
            end
        end
        check("t2_fail_state", state_dbg, 8);
        check("t2_link_fail", link_fail, 1);
        check("t2_phyreset", phyreset, 1);
        repeat (5) tick();
        check("t2_fail_hold", state_dbg, 8);

        // ---- 6b. enable=0 beats restart; retry retained ----
        enable = 0; restart = 1; tick(); restart = 0;
        check("t6_en_vs_restart", state_dbg, 0);
        check("t6_retry_kept", retry_cnt, 3);
        check("t6_fail_clear", link_fail, 0);
        enable = 1;
        wait_state(8, 60, "t6_refail");
        check("t6_retry4", retry_cnt, 4);

        // ---- 3. restart in FAIL ----
        restart = 1; tick(); restart = 0;
        check("t3_retry_clr", retry_cnt, 0);
        check("t3_fail_clr", link_fail, 0);
        wait_state(2, 10, "t3_phyrst");
        count_in_state(2, n);
        check("t3_phyrst_len", n, 4);
        check("t3_startcomm", StartComm, 1);

        // ---- 6a. reset mid WAIT_LINK ----
        wait_state(4, 10, "t6_init");
        CommInit = 1; tick(); CommInit = 0;
        rst_n = 0; tick(); rst_n = 1;
        check("t6_rst_state", state_dbg, 0);
        check("t6_rst_phyreset", phyreset, 1);
        check("t6_rst_ready", link_ready, 0);

        // ---- 6c. tie-breaks on the timeout cycle ----
        wait_state(4, 20, "t6_tie_init");
        repeat (INIT - 1) tick();
        CommInit = 1; tick(); CommInit = 0;
        check("t6_comminit_tie", state_dbg, 5);
        repeat (LINK - 1) tick();
        linkup = 1; tick();
        check("t6_linkup_tie", state_dbg, 6);

        // ---- randomized phase ----
        for (int seg = 0; seg < 12; seg++) begin
            prof = $urandom_range(0, 3);
            for (int c = 0; c < 300; c++) begin
                rst_n   = ($urandom_range(0, 599) != 0);
                enable  = ($urandom_range(0, 199) != 0);
                restart = ($urandom_range(0, 249) == 0);
                if (plllock) plllock = ($urandom_range(0, 149) != 0);
                else         plllock = ($urandom_range(0, 2) == 0);
                case (prof)
                    0: begin CommInit = 0; linkup = 0; end
                    1: begin
                        CommInit = ($urandom_range(0, 7) == 0);
                        if (linkup) linkup = ($urandom_range(0, 39) != 0);
                        else        linkup = ($urandom_range(0, 5) == 0);
                    end
                    2: begin
                        CommInit = ($urandom_range(0, 24) == 0);
                        if (linkup) linkup = ($urandom_range(0, 19) != 0);
                        else        linkup = ($urandom_range(0, 29) == 0);
                    end
                    default: begin
                        CommInit = ($urandom_range(0, 3) == 0);
                        if (linkup) linkup = ($urandom_range(0, 7) != 0);
                        else        linkup = ($urandom_range(0, 2) == 0);
                    end
                endcase
                tick();
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sata_link_ctrl.md
Name: sata_link_ctrl

Overview:
Per-port link bring-up sequencer for the SATA GTX/GTP PHY wrapper. Runs in the port's phyclk domain and drives that port's phyreset and StartComm inputs. Monitors CommInit, linkup and plllock, applies timeouts with bounded retry and backoff, and restarts on link loss. Presents a clean link_ready/link_fail status to the link layer. One instance per port.

Parameters:
C_RST_CYCLES, 16, cycles phyreset is held high per attempt (>=1)
C_INIT_TIMEOUT, 20'd400000, cycles allowed from StartComm pulse to CommInit
C_LINK_TIMEOUT, 20'd800000, cycles allowed from CommInit to linkup
C_BACKOFF, 20'd100000, idle cycles between failed attempts
C_MAX_RETRY, 3, failed attempts tolerated before FAIL (1..15)
C_LOSS_FILTER, 4, consecutive cycles of linkup low that count as link loss (1..255)

Ports:
phyclk  in  1  port PHY clock, the same net that feeds the port's phyclk0/phyclk1
rst_n  in  1  synchronous active-low reset
enable  in  1  level; high = bring up and hold the link, low = hold PHY in reset
restart  in  1  single-cycle pulse; forces a new bring-up and clears the retry count
plllock  in  1  PHY PLL lock
CommInit  in  1  OOB COMINIT received, from PHY
linkup  in  1  link up, from PHY
phyreset  out  1  to PHY phyreset
StartComm  out  1  to PHY StartComm, one-cycle pulse
link_ready  out  1  registered; high only in LINKED
link_fail  out  1  registered; high only in FAIL
retry_cnt  out  4  failed attempts since the last successful link or restart
state_dbg  out  4  current state encoding, for the oob2dbg/ChipScope bus

Behaviour:
- Reset (rst_n low at a phyclk edge): state=IDLE, phyreset=1, StartComm=0, link_ready=0, link_fail=0, retry_cnt=0, timer=0, loss counter=0.
- All outputs are registered. Every state change takes effect on the next edge.
- One 20-bit down-counter timer, loaded on entry to each timed state. A timeout fires when the timer reaches 0.
- States and encodings:
  - IDLE(0): phyreset=1. Go to WAIT_PLL when enable=1.
  - WAIT_PLL(1): phyreset=1. Go to PHY_RST when plllock=1; load timer=C_RST_CYCLES-1.
  - PHY_RST(2): phyreset=1. Go to START at timeout.
  - START(3): phyreset=0, StartComm=1 for exactly this one cycle. Go to WAIT_INIT; load C_INIT_TIMEOUT-1.
  - WAIT_INIT(4): on CommInit=1 go to WAIT_LINK and load C_LINK_TIMEOUT-1. On timeout, fail the attempt.
  - WAIT_LINK(5): on linkup=1 go to LINKED and clear retry_cnt. On timeout, fail the attempt.
  - LINKED(6): link_ready=1. A counter counts consecutive cycles with linkup=0 and clears when linkup=1. When it reaches C_LOSS_FILTER, go to PHY_RST; retry_cnt is not incremented.
  - BACKOFF(7): phyreset=1. Go to PHY_RST at timeout.
  - FAIL(8): phyreset=1, link_fail=1. Leave only on restart or enable=0.
- Fail the attempt: retry_cnt+1. If the new value >= C_MAX_RETRY go to FAIL; otherwise go to BACKOFF and load C_BACKOFF-1. retry_cnt saturates at 15.
- enable=0 in any state: go to IDLE next cycle with phyreset=1; retry_cnt is retained.
- restart=1 in any state: retry_cnt=0 and go to WAIT_PLL. Priority order: rst_n > enable=0 > restart > state logic.
- plllock drop in any state except IDLE/WAIT_PLL/FAIL: go to WAIT_PLL immediately. link_ready drops the next cycle; retry_cnt unchanged.
- Simultaneous events: CommInit and timeout in the same WAIT_INIT cycle → CommInit wins. linkup and timeout in the same WAIT_LINK cycle → linkup wins.
- CommInit/linkup are sampled with no added synchronizer; both are already in the phyclk domain.

Test Plan:
Use small parameters: RST=4, INIT=20, LINK=20, BACKOFF=10, MAX_RETRY=3, LOSS=4.
1. Nominal. rst_n release, enable=1, plllock=1; CommInit 5 cycles after StartComm; linkup 3 cycles later → phyreset high for exactly 4 cycles, then a single StartComm pulse; link_ready=1 one cycle after linkup; retry_cnt=0.
2. No device, CommInit never arrives → three attempts separated by 10-cycle BACKOFF; retry_cnt steps 1,2,3; link_fail=1 about 20 cycles after the third StartComm; phyreset=1 held.
3. restart in FAIL → retry_cnt=0, link_fail=0 next cycle; the next StartComm follows the 4-cycle phyreset.
4. Link-loss filter from LINKED. linkup low for 3 cycles then high → stays LINKED. linkup low for 4 cycles → PHY_RST, link_ready=0, retry_cnt unchanged.
5. plllock deasserts during WAIT_LINK → state_dbg=1 next cycle; bring-up resumes when plllock returns.
6. Priority and tie-break. rst_n low mid-WAIT_LINK → all outputs take their reset values next edge. enable=0 and restart in the same cycle → IDLE. CommInit arriving on the timeout cycle → WAIT_LINK.
